// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Provides the FSM state enum, the funct3 operation encodings and helpers
// that classify which operands of an op are interpreted as signed.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV, REM (MULHSU treats rs2 as unsigned)
    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division step (combinational).
// Ports: rem_i/quo_i  current partial remainder and dividend/quotient shift reg
//        divisor_i    divisor magnitude
//        rem_nxt_c/quo_nxt_c  values after shifting in one dividend bit
module div_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_nxt_c,
    output logic [DATA_WIDTH-1:0] quo_nxt_c
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W:0] shifted;
    logic       ge;

    // Partial remainder is always < divisor, so the shifted value fits W+1 bits
    // and the restored/subtracted remainder fits back into W bits.
    always_comb begin
        shifted   = {rem_i, quo_i[W-1]};
        ge        = (shifted >= {1'b0, divisor_i});
        rem_nxt_c = ge ? W'(shifted - {1'b0, divisor_i}) : shifted[W-1:0];
        quo_nxt_c = {quo_i[W-2:0], ge};
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit.
// Ports: clk, rst (sync active-low), start (level, op in execute),
//        funct3 (M-extension op), op1/op2 (rs1/rs2), flush (kill op),
//        stall (start & ~done), done (result valid), result (registered).
// Build option: MULDIV_FAST_MUL_EN makes multiplies single-cycle (combinational
// product at capture); the divide path is the same in both builds.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  flush,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned W2    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [W-1:0]     MIN_NEG   = {1'b1, {(W-1){1'b0}}};

    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2:0]        f3_q,     f3_d;
    logic [W-1:0]      a_q,      a_d;       // multiplicand or divisor magnitude
    logic [W2-1:0]     prod_q,   prod_d;    // product, or {remainder, quotient}
    logic              neg_q,    neg_d;     // result sign (product / quotient)
    logic              s1_q,     s1_d;      // dividend sign, drives remainder sign
    logic [W-1:0]      result_q, result_d;

    logic          s1, s2;
    logic [W-1:0]  mag1, mag2;
    logic          div_zero, div_ovf;
    logic [W:0]    mul_sum;
    logic [W2-1:0] mul_nxt;
    logic [W-1:0]  rem_nxt, quo_nxt;
`ifdef MULDIV_FAST_MUL_EN
    logic [W2-1:0] fast_prod;
`endif

    // Sign-correct the full product and pick low (MUL) or high word
    function automatic logic [W-1:0] mul_result(input logic [2:0] f3,
                                                input logic neg,
                                                input logic [W2-1:0] p);
        logic [W2-1:0] v;
        v = neg ? W2'(-p) : p;
        return (f3 == F3_MUL) ? v[W-1:0] : v[W2-1:W];
    endfunction

    // Sign-correct quotient or remainder; remainder takes the dividend's sign
    function automatic logic [W-1:0] div_result(input logic [2:0] f3,
                                                input logic neg,
                                                input logic s1n,
                                                input logic [W-1:0] rem,
                                                input logic [W-1:0] quo);
        if (f3[1]) begin
            return s1n ? W'(-rem) : rem;
        end
        return neg ? W'(-quo) : quo;
    endfunction

    div_step #(
        .DATA_WIDTH (W)
    ) u_div_step (
        .rem_i      (prod_q[W2-1:W]),
        .quo_i      (prod_q[W-1:0]),
        .divisor_i  (a_q),
        .rem_nxt_c  (rem_nxt),
        .quo_nxt_c  (quo_nxt)
    );

    // Operand conditioning at capture
    always_comb begin
        s1       = rs1_signed(funct3) & op1[W-1];
        s2       = rs2_signed(funct3) & op2[W-1];
        mag1     = s1 ? W'(-op1) : op1;
        mag2     = s2 ? W'(-op2) : op2;
        div_zero = (op2 == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (op1 == MIN_NEG) && (op2 == {W{1'b1}});
    end

    // Shift-add step: multiplier sits in the low half and is consumed LSB first
    always_comb begin
        mul_sum = {1'b0, prod_q[W2-1:W]} + {1'b0, a_q};
        mul_nxt = prod_q[0] ? {mul_sum, prod_q[W-1:1]} : {1'b0, prod_q[W2-1:1]};
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fast_prod = W2'(mag1) * W2'(mag2);
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        a_d      = a_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        s1_d     = s1_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d  = funct3;
                    s1_d  = s1;
                    neg_d = s1 ^ s2;
                    cnt_d = '0;
                    if (funct3[2]) begin
                        a_d    = mag2;
                        prod_d = {{W{1'b0}}, mag1};
                        if (div_zero) begin
                            state_d  = S_DONE;
                            result_d = funct3[1] ? op1 : {W{1'b1}};
                        end else if (div_ovf) begin
                            state_d  = S_DONE;
                            result_d = funct3[1] ? {W{1'b0}} : MIN_NEG;
                        end else begin
                            state_d = S_DIV;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        prod_d   = fast_prod;
                        result_d = mul_result(funct3, s1 ^ s2, fast_prod);
                        state_d  = S_DONE;
`else
                        a_d     = mag1;
                        prod_d  = {{W{1'b0}}, mag2};
                        state_d = S_MUL;
`endif
                    end
                end
            end
            S_MUL: begin
                prod_d = mul_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d  = S_DONE;
                    result_d = mul_result(f3_q, neg_q, mul_nxt);
                end
            end
            S_DIV: begin
                prod_d = {rem_nxt, quo_nxt};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d  = S_DONE;
                    result_d = div_result(f3_q, neg_q, s1_q, rem_nxt, quo_nxt);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides capture and completion; result is left untouched
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            s1_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            s1_q     <= s1_d;
            result_q <= result_d;
        end
    end

    assign done   = rst & (state_q == S_DONE);
    assign stall  = start & ~done;
    assign result = result_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  level; high while an M-extension instruction occupies execute.
REQ-005 SHALL have port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op1  input  DATA_WIDTH  forwarded rs1 operand.
REQ-007 SHALL have port op2  input  DATA_WIDTH  forwarded rs2 operand.
REQ-008 SHALL have port flush  input  1  kill the in-flight operation.
REQ-009 SHALL have port stall  output  1  hold fetch/decode/execute.
REQ-010 SHALL have port done  output  1  result valid this cycle.
REQ-011 SHALL have port result  output  DATA_WIDTH  registered result.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL capture op1, op2 and funct3 only in IDLE with start=1 and flush=0.
- On capture, operands become magnitudes and the result-sign flag is latched.
- Signed ops: MUL, MULH, DIV, REM.
- MULHSU: op1 signed, op2 unsigned.
REQ-014 SHALL on capture go IDLE->MUL for funct3[2]=0 and IDLE->DIV for funct3[2]=1, with a 5-bit step counter cleared.
REQ-015 SHALL in MUL perform one radix-2 shift-add step per cycle for 32 cycles into a 2*DATA_WIDTH product, then go to DONE.
REQ-016 SHALL in DIV perform one restoring-division step per cycle for 32 cycles, then go to DONE.
REQ-017 SHALL go IDLE->DONE in one cycle (fast path) for divide-by-zero: quotient all ones, remainder = op1.
REQ-018 SHALL go IDLE->DONE in one cycle (fast path) for signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
REQ-019 SHALL load result on entry to DONE.
- Sign correction is applied at that load.
- MUL returns the low word; MULH, MULHSU and MULHU return the high word.
- Remainder sign follows the dividend.
REQ-020 SHALL assert done=1 in DONE only; DONE->IDLE unconditionally; start is ignored in DONE.
REQ-021 SHALL drive stall = start & ~done, combinationally.
REQ-022 SHALL give 33 cycles of iterative latency: done is high in the 33rd cycle after the capture edge.
REQ-023 SHALL give 1 cycle of fast-path latency: done is high in the cycle after the capture edge.
REQ-024 SHALL treat back-to-back operations as follows: the instruction following DONE is captured from IDLE, costing one stall cycle.
REQ-025 SHALL on flush=1 in any state go to IDLE next cycle, with no done pulse and result unchanged.
REQ-026 SHALL give flush priority over start and over step completion when they occur in the same cycle.
REQ-027 SHALL hold result stable from DONE until the next load.

Reset
REQ-028 SHALL on rst=0 at a clock edge set state=IDLE, counter=0, result=0, and all operand/product registers to 0.
REQ-029 SHALL give done=0 and stall=start during reset; reset mid-operation abandons the operation.

Configuration
REQ-030 SHALL, with MULDIV_FAST_MUL_EN defined, compute multiply ops combinationally at capture and go IDLE->DONE with 1-cycle latency; the MUL state is unused.
REQ-031 SHALL, without MULDIV_FAST_MUL_EN, use iterative 33-cycle multiply; the divide path is identical in both builds.

Structure
REQ-032 SHALL place the FSM state enum and funct3 op constants in shared package muldiv_pkg.
REQ-033 SHALL implement one restoring-division step as combinational sub-module div_step, instantiated once.

Verification
REQ-034 SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done 33 cycles after capture; stall high for 33 cycles.
REQ-035 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, and MULH of the same operands -> 0x00000000.
REQ-036 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both with done 1 cycle after capture.
REQ-037 SHALL cover DIVU 100 / 0 -> 0xFFFFFFFF, REMU 100 / 0 -> 100, and REM 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFF.
REQ-038 SHALL cover DIV 1000 / 7 with flush at the 10th DIV cycle -> IDLE next cycle, no done, result unchanged, stall follows start.
REQ-039 SHALL cover rst=0 during MUL step 20 -> IDLE, result=0, and a subsequent DIVU 9/3 -> 3.
